// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor conditioning front end.
package sensor_pkg;

    typedef enum logic [0:0] {
        PRIME,
        RUN
    } state_e;

    localparam int unsigned MOIST_W = 8;
    localparam int unsigned LEVEL_W = 2;

    // Tank level codes as seen on Water_sensor = {high, low}
    localparam logic [LEVEL_W-1:0] EMPTY = 2'b00;
    localparam logic [LEVEL_W-1:0] LOW   = 2'b01;
    localparam logic [LEVEL_W-1:0] FULL  = 2'b11;

endpackage

// File: rtl/float_debounce.sv
// Float switch conditioner: two-flop synchroniser followed by a hold-time debouncer.
// The stable output only follows the synchronised input after it has differed for
// DEBOUNCE_CYCLES consecutive cycles.
module float_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic stable
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    // Count cycles of disagreement; adopt the new level once it has persisted long enough
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor conditioner: boxcar-averages ADC moisture samples and debounces the two tank
// float switches for the irrigation controller.
// Optional stuck-ADC detection is built when SENSOR_STUCK_DETECT_EN is defined.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned STUCK_LIMIT     = 64
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic [MOIST_W-1:0] Raw_moisture,
    input  logic               Raw_valid,
    input  logic               Float_low,
    input  logic               Float_high,
    output logic [MOIST_W-1:0] Moisture_sensor,
    output logic [LEVEL_W-1:0] Water_sensor,
    output logic               Data_ready,
    output logic               Sensor_fault
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = MOIST_W + AVG_LOG2;

    logic [MOIST_W-1:0]  win_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;      // also serves as the fill count while priming
    logic [SUM_W-1:0]    sum_q, sum_next;
    state_e              state_q, state_d;
    logic                load;
    logic [MOIST_W-1:0]  moist_q;
    logic                ready_q;
    logic                low_stable, high_stable;

    // Running sum; the buffer is zero while priming, so the same update works in both states
    always_comb begin
        sum_next = sum_q + SUM_W'(Raw_moisture) - SUM_W'(win_q[ptr_q]);
    end

    // Next state and output-load decision
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            PRIME: begin
                if (Raw_valid && (ptr_q == AVG_LOG2'(DEPTH - 1))) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                load = Raw_valid;
            end
            default: state_d = PRIME;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample ring buffer, ring pointer and running sum
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
        end else if (Raw_valid) begin
            win_q[ptr_q] <= Raw_moisture;
            ptr_q        <= ptr_q + 1'b1;
            sum_q        <= sum_next;
        end
    end

    // Averaged output and its one-cycle strobe
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            moist_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (load) begin
                moist_q <= sum_next[SUM_W-1:AVG_LOG2];
            end
            ready_q <= load;
        end
    end

    assign Moisture_sensor = moist_q;
    assign Data_ready      = ready_q;

    float_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_low_db (
        .clk      (CLK),
        .rst_n    (Reset_n),
        .async_in (Float_low),
        .stable   (low_stable)
    );

    float_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_high_db (
        .clk      (CLK),
        .rst_n    (Reset_n),
        .async_in (Float_high),
        .stable   (high_stable)
    );

    // Code 10 is passed through; the controller decides what it means
    assign Water_sensor = {high_stable, low_stable};

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int unsigned STUCK_W = $clog2(STUCK_LIMIT + 1);

    logic [MOIST_W-1:0] prev_q;
    logic               prev_valid_q;
    logic [STUCK_W-1:0] stuck_cnt_q;
    logic               fault_q;

    // Count repeats of the previous sample; flag is sticky until a differing sample
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            stuck_cnt_q  <= '0;
            fault_q      <= 1'b0;
        end else if (Raw_valid) begin
            prev_q       <= Raw_moisture;
            prev_valid_q <= 1'b1;
            if (prev_valid_q && (Raw_moisture == prev_q)) begin
                if (stuck_cnt_q != STUCK_W'(STUCK_LIMIT)) begin
                    stuck_cnt_q <= stuck_cnt_q + 1'b1;
                end
                if (stuck_cnt_q == STUCK_W'(STUCK_LIMIT - 1)) begin
                    fault_q <= 1'b1;
                end
            end else begin
                stuck_cnt_q <= '0;
                fault_q     <= 1'b0;
            end
        end
    end

    assign Sensor_fault = fault_q;
`else
    assign Sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (AVG_LOG2=2, DEBOUNCE_CYCLES=8, STUCK_LIMIT=4).
module tb_sensor_conditioner;
    import sensor_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Raw_moisture = 8'd0;
    logic       Raw_valid = 1'b0;
    logic       Float_low = 1'b0;
    logic       Float_high = 1'b0;
    logic [7:0] Moisture_sensor;
    logic [1:0] Water_sensor;
    logic       Data_ready;
    logic       Sensor_fault;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected averages queued when a sample is driven
    logic [7:0] exp_q[$];
    logic [7:0] m_win [4];
    int         m_cnt;
    int         m_ptr;
    logic [7:0] m_out;

    sensor_conditioner #(
        .AVG_LOG2        (2),
        .DEBOUNCE_CYCLES (8),
        .STUCK_LIMIT     (4)
    ) dut (
        .CLK             (CLK),
        .Reset_n         (Reset_n),
        .Raw_moisture    (Raw_moisture),
        .Raw_valid       (Raw_valid),
        .Float_low       (Float_low),
        .Float_high      (Float_high),
        .Moisture_sensor (Moisture_sensor),
        .Water_sensor    (Water_sensor),
        .Data_ready      (Data_ready),
        .Sensor_fault    (Sensor_fault)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_win[i] = 8'd0;
        m_cnt = 0;
        m_ptr = 0;
        m_out = 8'd0;
        exp_q.delete();
    endtask

    // One clock cycle of moisture stimulus; the scoreboard pops on each observed output
    task automatic step(input logic valid, input logic [7:0] value);
        int s;
        @(negedge CLK);
        Raw_valid    = valid;
        Raw_moisture = value;
        if (valid) begin
            m_win[m_ptr] = value;
            m_ptr        = (m_ptr + 1) % 4;
            m_cnt++;
            if (m_cnt >= 4) begin
                s = 0;
                for (int i = 0; i < 4; i++) s += int'(m_win[i]);
                exp_q.push_back(8'(s / 4));
            end
        end
        @(posedge CLK);
        #1;
        Raw_valid = 1'b0;
        checks++;
        if (Data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: Data_ready=1 Moisture_sensor=%0d, required Data_ready=0",
                         Moisture_sensor);
            end else begin
                m_out = exp_q.pop_front();
                if (Moisture_sensor !== m_out) begin
                    errors++;
                    $display("FAIL average: Moisture_sensor=%0d, required %0d", Moisture_sensor, m_out);
                end
            end
        end else if (exp_q.size() != 0) begin
            m_out = exp_q.pop_front();
            errors++;
            $display("FAIL missing_ready: Data_ready=%b, required 1 with Moisture_sensor=%0d",
                     Data_ready, m_out);
        end else if (Moisture_sensor !== m_out) begin
            errors++;
            $display("FAIL hold: Moisture_sensor=%0d, required %0d", Moisture_sensor, m_out);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({Moisture_sensor, Water_sensor, Data_ready, Sensor_fault} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: moist=%0d water=%b ready=%b fault=%b, required all 0",
                     Moisture_sensor, Water_sensor, Data_ready, Sensor_fault);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_prime_reset();
        step(1'b1, 8'd50);
        step(1'b1, 8'd60);
        @(negedge CLK);
        Reset_n = 1'b0;
        #2;
        checks++;
        if (Moisture_sensor !== 8'd0 || Data_ready !== 1'b0) begin
            errors++;
            $display("FAIL prime_reset: moist=%0d ready=%b, required 0/0", Moisture_sensor, Data_ready);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 8'd100);
        checks++;
        if (Moisture_sensor !== 8'd100) begin
            errors++;
            $display("FAIL prime_first: Moisture_sensor=%0d, required 100", Moisture_sensor);
        end
        step(1'b0, 8'd0);
    endtask

    task automatic test_average();
        for (int k = 0; k < 4; k++) step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        checks++;
        if (Moisture_sensor !== 8'd125) begin
            errors++;
            $display("FAIL avg_125: Moisture_sensor=%0d, required 125", Moisture_sensor);
        end
        step(1'b1, 8'd200);
        checks++;
        if (Moisture_sensor !== 8'd150) begin
            errors++;
            $display("FAIL avg_150: Moisture_sensor=%0d, required 150", Moisture_sensor);
        end
        step(1'b1, 8'd3);
        step(1'b1, 8'd0);
        step(1'b1, 8'd0);
        step(1'b1, 8'd0);
        checks++;
        if (Moisture_sensor !== 8'd0) begin
            errors++;
            $display("FAIL avg_trunc: Moisture_sensor=%0d, required 0", Moisture_sensor);
        end
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
    endtask

    task automatic test_float_single();
        logic [1:0] want;
        @(negedge CLK);
        Float_low = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge CLK);
            #1;
            want = (i >= 10) ? LOW : EMPTY;
            checks++;
            if (Water_sensor !== want) begin
                errors++;
                $display("FAIL low_delay: cycle %0d Water_sensor=%b, required %b", i, Water_sensor, want);
            end
        end
        // 5-cycle glitch on the upper float must be rejected
        @(negedge CLK);
        Float_high = 1'b1;
        repeat (5) @(negedge CLK);
        Float_high = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (Water_sensor !== LOW) begin
                errors++;
                $display("FAIL glitch: cycle %0d Water_sensor=%b, required %b", i, Water_sensor, LOW);
            end
        end
        @(negedge CLK);
        Float_low = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        checks++;
        if (Water_sensor !== EMPTY) begin
            errors++;
            $display("FAIL low_fall: Water_sensor=%b, required %b", Water_sensor, EMPTY);
        end
    endtask

    task automatic test_float_both();
        logic [1:0] want;
        @(negedge CLK);
        Float_low  = 1'b1;
        Float_high = 1'b1;
        // Moisture samples run concurrently; step() checks Data_ready every cycle
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 8'(10 + k));
            want = (k >= 9) ? FULL : EMPTY;
            checks++;
            if (Water_sensor !== want) begin
                errors++;
                $display("FAIL both_rise: step %0d Water_sensor=%b, required %b", k, Water_sensor, want);
            end
        end
    endtask

    task automatic test_stuck();
        logic want;
        step(1'b1, 8'd5);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'd77);
`ifdef SENSOR_STUCK_DETECT_EN
            want = (k == 5);
`else
            want = 1'b0;
`endif
            checks++;
            if (Sensor_fault !== want) begin
                errors++;
                $display("FAIL stuck: sample %0d Sensor_fault=%b, required %b", k, Sensor_fault, want);
            end
        end
        step(1'b1, 8'd78);
        checks++;
        if (Sensor_fault !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clear: Sensor_fault=%b, required 0", Sensor_fault);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'd90);
        checks++;
        if (Data_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ready: Data_ready=%b, required 1", Data_ready);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Moisture_sensor, Water_sensor, Data_ready, Sensor_fault} !== 12'd0) begin
            errors++;
            $display("FAIL async_reset: moist=%0d water=%b ready=%b fault=%b, required all 0",
                     Moisture_sensor, Water_sensor, Data_ready, Sensor_fault);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 8'd40);
        checks++;
        if (Moisture_sensor !== 8'd40) begin
            errors++;
            $display("FAIL reprime: Moisture_sensor=%0d, required 40", Moisture_sensor);
        end
        step(1'b0, 8'd0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prime_reset();
        test_average();
        test_float_single();
        test_float_both();
        test_stuck();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
